// File: rtl/sys_inst_sequencer_if.sv
// Instruction-source bus between the CPU fetch stage, the user instruction memory,
// the system ROM and the sequencer.
interface sys_inst_sequencer_if #(
  parameter int IDX_W = 4
);
  logic             sys_req;
  logic             sys_sel;
  logic             cpu_stall;
  logic [31:0]      rom_data;
  logic [31:0]      user_inst;
  logic [31:0]      inst_out;
  logic [IDX_W-1:0] rom_idx;
  logic             active;
  logic             pc_hold;
  logic             sys_ack;
  logic             done;
  logic             err;

  modport master (
    output sys_req, sys_sel, cpu_stall, rom_data, user_inst,
    input  inst_out, rom_idx, active, pc_hold, sys_ack, done, err
  );

  modport slave (
    input  sys_req, sys_sel, cpu_stall, rom_data, user_inst,
    output inst_out, rom_idx, active, pc_hold, sys_ack, done, err
  );
endinterface

// File: rtl/sys_inst_sequencer.sv
// Hands the CPU instruction stream to a system ROM routine, drains the pipeline
// with NOPs, then returns control to user instruction memory.
//
// state | meaning
// IDLE  | user instructions pass through, waiting for a request edge
// ISSUE | PC frozen, ROM index walks the selected routine
// DRAIN | PC frozen, NOPs injected
// DONE  | single-cycle completion pulse, may accept a new request
module sys_inst_sequencer #(
  parameter int          IDX_W     = 4,
  parameter int          IN_BASE   = 1,
  parameter int          IN_LEN    = 4,
  parameter int          OUT_BASE  = 5,
  parameter int          OUT_LEN   = 5,
  parameter int          DRAIN_CYC = 2,
  parameter logic [31:0] NOP       = 32'h00000013
) (
  input logic           en,
  input logic           reset,
  sys_inst_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] IN_B     = IDX_W'(IN_BASE);
  localparam logic [IDX_W-1:0] OUT_B    = IDX_W'(OUT_BASE);
  localparam logic [IDX_W-1:0] IN_REM   = IDX_W'(IN_LEN - 1);
  localparam logic [IDX_W-1:0] OUT_REM  = IDX_W'(OUT_LEN - 1);
  localparam logic [3:0]       DRN_INIT = 4'(DRAIN_CYC - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] rem_q, rem_d;
  logic [3:0]       drn_q, drn_d;
  logic             req_d1;
  logic             req_edge;
  logic             ack_d, err_d;
  logic             active_q, pc_hold_q, done_q, ack_q, err_q;

  assign req_edge = bus.sys_req & ~req_d1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    drn_d   = drn_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (req_edge) begin
          idx_d   = bus.sys_sel ? OUT_B : IN_B;
          rem_d   = bus.sys_sel ? OUT_REM : IN_REM;
          state_d = S_ISSUE;
          ack_d   = 1'b1;
        end
      end
      S_ISSUE: begin
        err_d = req_edge;
        if (!bus.cpu_stall) begin
          if (rem_q == '0) begin
            drn_d   = DRN_INIT;
            state_d = S_DRAIN;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            rem_d = rem_q - IDX_W'(1);
          end
        end
      end
      S_DRAIN: begin
        err_d = req_edge;
        if (!bus.cpu_stall) begin
          if (drn_q == 4'd0) state_d = S_DONE;
          else               drn_d   = drn_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.inst_out = bus.user_inst;
    case (state_q)
      S_ISSUE: bus.inst_out = bus.rom_data;
      S_DRAIN: bus.inst_out = NOP;
      default: bus.inst_out = bus.user_inst;
    endcase
  end

  // Status flags are registered from the next state so they align with it.
  always_ff @(posedge en) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      rem_q     <= '0;
      drn_q     <= 4'd0;
      req_d1    <= 1'b0;
      active_q  <= 1'b0;
      pc_hold_q <= 1'b0;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      drn_q     <= drn_d;
      req_d1    <= bus.sys_req;
      active_q  <= (state_d != S_IDLE);
      pc_hold_q <= (state_d == S_ISSUE) || (state_d == S_DRAIN);
      done_q    <= (state_d == S_DONE);
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  assign bus.rom_idx = idx_q;
  assign bus.active  = active_q;
  assign bus.pc_hold = pc_hold_q;
  assign bus.done    = done_q;
  assign bus.sys_ack = ack_q;
  assign bus.err     = err_q;

endmodule
